// File: rtl/spk_tone_decoder_if.sv
`timescale 1ns/1ps
// Event port of spk_tone_decoder: one (period, duration) event per
// valid/ready handshake. The decoder drives through the master modport.
interface spk_tone_decoder_if #(
    parameter int PW    = 8,
    parameter int DUR_W = 16
);
    logic             evt_valid;
    logic             evt_ready;
    logic [PW-1:0]    evt_period;
    logic [DUR_W-1:0] evt_duration;

    modport master (
        output evt_valid,
        output evt_period,
        output evt_duration,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_period,
        input  evt_duration,
        output evt_ready
    );
endinterface

// File: rtl/spk_tone_decoder.sv
`timescale 1ns/1ps
// spk_tone_decoder: measures half-periods of the 2-bit speaker stream,
// locks onto stable tones and emits one (period, duration) event per tone.
// Optional silence reporting is compiled in with TONE_DEC_SILENCE_EN.
module spk_tone_decoder #(
    parameter int MAX_COUNT = 255,
    parameter int STABLE_N  = 2,
    parameter int TOL       = 1,
    parameter int DUR_W     = 16,
    localparam int PW       = $clog2(MAX_COUNT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          speaker,
    spk_tone_decoder_if.master  evt,
    output logic                overflow
);

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED} state_t;

    localparam logic [PW-1:0]    MAX_V    = PW'(MAX_COUNT);
    localparam logic [PW-1:0]    MAX_M1_V = PW'(MAX_COUNT - 1);
    localparam logic [PW-1:0]    TOL_V    = PW'(TOL);
    localparam logic [DUR_W-1:0] STABLE_V = DUR_W'(STABLE_N);

    logic [1:0]       spk_r_q, spk_r_d, spk_rr_q, spk_rr_d;
    logic [PW-1:0]    hp_cnt_q, hp_cnt_d;
    state_t           state_q, state_d;
    logic [PW-1:0]    cand_q, cand_d;
    // Match count while acquiring, held duration once locked.
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             evt_valid_q, evt_valid_d;
    logic [PW-1:0]    evt_period_q, evt_period_d;
    logic [DUR_W-1:0] evt_duration_q, evt_duration_d;
    logic             overflow_q, overflow_d;
`ifdef TONE_DEC_SILENCE_EN
    logic [DUR_W-1:0] sil_q, sil_d;
    logic [PW-1:0]    sil_tick_q, sil_tick_d;
`endif

    logic             edge_det, timeout, is_match, accept, emit;
    logic [PW-1:0]    diff, emit_period;
    logic [DUR_W-1:0] emit_dur;

    // Input pipeline, edge detection and half-period counter.
    always_comb begin
        spk_r_d  = speaker;
        spk_rr_d = spk_r_q;
        edge_det = (spk_r_q != spk_rr_q);
        if (edge_det) begin
            hp_cnt_d = PW'(1);
        end else if (hp_cnt_q != MAX_V) begin
            hp_cnt_d = hp_cnt_q + PW'(1);
        end else begin
            hp_cnt_d = hp_cnt_q;
        end
        // Single cycle in which the counter steps onto MAX_COUNT.
        timeout  = !edge_det && (hp_cnt_q == MAX_M1_V);
        diff     = (hp_cnt_q > cand_q) ? (hp_cnt_q - cand_q) : (cand_q - hp_cnt_q);
        is_match = (diff <= TOL_V);
    end

    // Tone tracking FSM: next state, candidate, counters and emit request.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        emit        = 1'b0;
        emit_period = cand_q;
        emit_dur    = cnt_q;
`ifdef TONE_DEC_SILENCE_EN
        sil_d       = sil_q;
        sil_tick_d  = sil_tick_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (edge_det) begin
                    state_d = S_ACQUIRE;
                    cnt_d   = '0;
`ifdef TONE_DEC_SILENCE_EN
                    if (sil_q != '0) begin
                        emit        = 1'b1;
                        emit_period = '0;
                        emit_dur    = sil_q;
                    end
                    sil_d      = '0;
                    sil_tick_d = '0;
`endif
                end
`ifdef TONE_DEC_SILENCE_EN
                else if (sil_q != '0) begin
                    if (sil_tick_q == MAX_M1_V) begin
                        sil_tick_d = '0;
                        if (sil_q != '1) begin
                            sil_d = sil_q + DUR_W'(1);
                        end
                    end else begin
                        sil_tick_d = sil_tick_q + PW'(1);
                    end
                end
`endif
            end
            S_ACQUIRE: begin
                if (edge_det) begin
                    if ((cnt_q != '0) && is_match) begin
                        cnt_d = cnt_q + DUR_W'(1);
                        if ((cnt_q + DUR_W'(1)) >= STABLE_V) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        cand_d = hp_cnt_q;
                        cnt_d  = DUR_W'(1);
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_LOCKED: begin
                if (edge_det) begin
                    if (is_match) begin
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + DUR_W'(1);
                        end
                    end else begin
                        emit    = 1'b1;
                        state_d = S_ACQUIRE;
                        cand_d  = hp_cnt_q;
                        cnt_d   = DUR_W'(1);
                    end
                end else if (timeout) begin
                    emit    = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
`ifdef TONE_DEC_SILENCE_EN
                    sil_d      = DUR_W'(1);
                    sil_tick_d = '0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Single-entry output register with sticky overflow on dropped events.
    always_comb begin
        evt_valid_d    = evt_valid_q;
        evt_period_d   = evt_period_q;
        evt_duration_d = evt_duration_q;
        overflow_d     = overflow_q;
        accept         = evt_valid_q && evt.evt_ready;
        if (accept) begin
            evt_valid_d = 1'b0;
        end
        if (emit) begin
            if (!evt_valid_q || accept) begin
                evt_valid_d    = 1'b1;
                evt_period_d   = emit_period;
                evt_duration_d = emit_dur;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            spk_r_q        <= '0;
            spk_rr_q       <= '0;
            hp_cnt_q       <= MAX_V;
            state_q        <= S_IDLE;
            cand_q         <= '0;
            cnt_q          <= '0;
            evt_valid_q    <= 1'b0;
            evt_period_q   <= '0;
            evt_duration_q <= '0;
            overflow_q     <= 1'b0;
`ifdef TONE_DEC_SILENCE_EN
            sil_q          <= '0;
            sil_tick_q     <= '0;
`endif
        end else begin
            spk_r_q        <= spk_r_d;
            spk_rr_q       <= spk_rr_d;
            hp_cnt_q       <= hp_cnt_d;
            state_q        <= state_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            evt_valid_q    <= evt_valid_d;
            evt_period_q   <= evt_period_d;
            evt_duration_q <= evt_duration_d;
            overflow_q     <= overflow_d;
`ifdef TONE_DEC_SILENCE_EN
            sil_q          <= sil_d;
            sil_tick_q     <= sil_tick_d;
`endif
        end
    end

    assign evt.evt_valid    = evt_valid_q;
    assign evt.evt_period   = evt_period_q;
    assign evt.evt_duration = evt_duration_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_spk_tone_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench for spk_tone_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares on every accepted handshake.
module tb_spk_tone_decoder;

    typedef struct packed {
        logic [7:0]  period;
        logic [15:0] dur;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speaker = 2'b00;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    evt_t exp_q[$];
    evt_t mon_e;

    spk_tone_decoder_if #(.PW(8), .DUR_W(16)) evt_if ();

    spk_tone_decoder #(
        .MAX_COUNT(255),
        .STABLE_N(2),
        .TOL(1),
        .DUR_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .speaker(speaker),
        .evt(evt_if),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Each edge is preceded by `spacing` cycles, then speaker[0] toggles.
    task automatic tone(input int edges, input int spacing);
        for (int i = 0; i < edges; i++) begin
            tick(spacing);
            speaker = speaker ^ 2'b01;
        end
    endtask

    task automatic push(input int p, input int d);
        evt_t e;
        e.period = 8'(p);
        e.dur    = 16'(d);
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: actual period=%0d duration=%0d required no event",
                         evt_if.evt_period, evt_if.evt_duration);
            end else begin
                mon_e = exp_q.pop_front();
                check("evt_period", int'(evt_if.evt_period), int'(mon_e.period));
                check("evt_duration", int'(evt_if.evt_duration), int'(mon_e.dur));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        evt_if.evt_ready = 1'b1;

        // Reset values
        tick(3);
        check("reset_valid", int'(evt_if.evt_valid), 0);
        check("reset_period", int'(evt_if.evt_period), 0);
        check("reset_duration", int'(evt_if.evt_duration), 0);
        check("reset_overflow", int'(overflow), 0);
        rst = 1'b0;
        tick(5);

        // Single tone with timeout latency
        push(10, 19);
        tone(20, 10);
        lat = 0;
        while (lat < 400 && !evt_if.evt_valid) begin
            tick(1);
            lat++;
        end
        check("timeout_latency", lat, 256);
        tick(50);

        // Tone change
        push(10, 11);
        push(20, 8);
        tone(12, 10);
        tone(8, 20);
        tick(300);
        check("tone_change_overflow", int'(overflow), 0);

        // Tolerance: measurements 10, 11, 10, ...
        push(10, 15);
        for (int i = 0; i < 16; i++) begin
            tick((i % 2 == 1) ? 10 : 11);
            speaker = speaker ^ 2'b01;
        end
        tick(300);

        // Backpressure: second event dropped, first held
        evt_if.evt_ready = 1'b0;
        push(10, 11);
        tone(12, 10);
        tone(8, 20);
        tick(300);
        check("bp_valid", int'(evt_if.evt_valid), 1);
        check("bp_period_held", int'(evt_if.evt_period), 10);
        check("bp_duration_held", int'(evt_if.evt_duration), 11);
        check("bp_overflow", int'(overflow), 1);
        evt_if.evt_ready = 1'b1;
        tick(1);
        evt_if.evt_ready = 1'b0;
        check("bp_valid_after_accept", int'(evt_if.evt_valid), 0);
        check("bp_overflow_sticky", int'(overflow), 1);
        tick(3);
        evt_if.evt_ready = 1'b1;

        // Reset in the middle of a locked tone
        tone(6, 10);
        tick(4);
        rst = 1'b1;
        speaker = 2'b00;
        tick(1);
        check("rst_mid_valid", int'(evt_if.evt_valid), 0);
        check("rst_mid_period", int'(evt_if.evt_period), 0);
        check("rst_mid_duration", int'(evt_if.evt_duration), 0);
        check("rst_mid_overflow", int'(overflow), 0);
        rst = 1'b0;
        tick(20);
        push(10, 7);
        tone(8, 10);
        tick(300);

        // Silence between two tones
        push(10, 5);
        tone(6, 10);
        tick(600);
`ifdef TONE_DEC_SILENCE_EN
        push(0, 2);
`endif
        push(10, 5);
        tone(6, 10);
        tick(300);

        check("scoreboard_drained", exp_q.size(), 0);
        check("final_overflow", int'(overflow), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
